// File: rtl/hdmi_clock_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_clk_pkg
// Purpose  : Shared types and default timing constants for the HDMI clock
//            bring-up sequencer.
// Contents : state_e     - 3-bit sequencer state encoding (also on state_o)
//            DEF_*       - default timing parameters for the top level
// Revision : 1.0 - initial release
// ============================================================================
package hdmi_clk_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RESET  = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_DIV_SETTLE = 3'd3,
    ST_RUN        = 3'd4,
    ST_FAULT      = 3'd5
  } state_e;

  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 65536;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_DIV_SETTLE     = 8;
  localparam int DEF_MAX_RETRIES    = 4;
  localparam int DEF_SYNC_STAGES    = 2;

endpackage
`default_nettype wire

// File: rtl/hdmi_clock_sequencer_sync_ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_ff
// Purpose  : Multi-flop synchronizer for a single asynchronous bit.
// Ports    : clk  - destination clock
//            rst  - asynchronous active-high reset, clears all stages
//            d    - asynchronous input bit
//            q    - synchronized output (after STAGES flops)
// Revision : 1.0 - initial release
// ============================================================================
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/hdmi_clock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_clock_sequencer
// Purpose  : Brings up the HDMI clock tree: pulses PLL reset, waits for a
//            stable lock, releases the 5:1 divider, then the video/TMDS
//            reset. Lock loss or timeout retries; too many failures latch
//            a fault until restart or rst.
// Ports    : clk           - free-running board clock
//            rst           - asynchronous active-high reset
//            pll_lock      - PLL lock (asynchronous to clk)
//            restart       - one-cycle pulse, re-runs sequence, clears fault
//            pll_reset     - active-high PLL reset
//            clkdiv_resetn - active-low CLKDIV reset
//            video_reset   - active-high HDMI/TMDS reset
//            clocks_ready  - high only in RUN
//            fault         - retries exhausted (sticky)
//            retry_count   - failed attempts since rst/restart
//            state_o       - current state encoding
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_clock_sequencer
  import hdmi_clk_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int DIV_SETTLE     = DEF_DIV_SETTLE,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pll_lock,
  input  logic                             restart,
  output logic                             pll_reset,
  output logic                             clkdiv_resetn,
  output logic                             video_reset,
  output logic                             clocks_ready,
  output logic                             fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
  output logic [2:0]                       state_o
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD  = (STABLE_CYCLES > DIV_SETTLE) ? STABLE_CYCLES : DIV_SETTLE;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_ALL) + 1;
  localparam int RW      = $clog2(MAX_RETRIES + 1);

  logic lock_s;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   rc_q, rc_d;
  logic [RW-1:0]   rc_inc;
  logic            fail;
  logic            pll_reset_q, pll_reset_d;
  logic            clkdiv_resetn_q, clkdiv_resetn_d;
  logic            video_reset_q, video_reset_d;
  logic            clocks_ready_q, clocks_ready_d;
  logic            fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    fail    = 1'b0;
    rc_inc  = (rc_q == RW'(MAX_RETRIES)) ? rc_q : rc_q + RW'(1);

    if (restart) begin
      state_d = ST_PLL_RESET;
      cnt_d   = '0;
      rc_d    = '0;
    end else begin
      unique case (state_q)
        // PLL_RESET counts up from 0 so the post-reset pulse (counter
        // cleared by rst) has the same length as a retry pulse.
        ST_PLL_RESET: begin
          if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = CW'(LOCK_TIMEOUT - 1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = CW'(STABLE_CYCLES - 1);
          end else if (cnt_q == '0) begin
            fail = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            fail = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = ST_DIV_SETTLE;
            cnt_d   = CW'(DIV_SETTLE - 1);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_DIV_SETTLE: begin
          if (!lock_s) begin
            fail = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            fail = 1'b1;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_PLL_RESET;
          cnt_d   = '0;
        end
      endcase

      // A failure overrides any terminal count reached in the same cycle.
      if (fail) begin
        rc_d    = rc_inc;
        cnt_d   = '0;
        state_d = (rc_inc == RW'(MAX_RETRIES)) ? ST_FAULT : ST_PLL_RESET;
      end
    end

    // Outputs are decoded from the next state so they change together
    // with state_q.
    pll_reset_d     = (state_d == ST_PLL_RESET) || (state_d == ST_FAULT);
    clkdiv_resetn_d = (state_d == ST_DIV_SETTLE) || (state_d == ST_RUN);
    video_reset_d   = (state_d != ST_RUN);
    clocks_ready_d  = (state_d == ST_RUN);
    fault_d         = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_PLL_RESET;
      cnt_q           <= '0;
      rc_q            <= '0;
      pll_reset_q     <= 1'b1;
      clkdiv_resetn_q <= 1'b0;
      video_reset_q   <= 1'b1;
      clocks_ready_q  <= 1'b0;
      fault_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      rc_q            <= rc_d;
      pll_reset_q     <= pll_reset_d;
      clkdiv_resetn_q <= clkdiv_resetn_d;
      video_reset_q   <= video_reset_d;
      clocks_ready_q  <= clocks_ready_d;
      fault_q         <= fault_d;
    end
  end

  assign pll_reset     = pll_reset_q;
  assign clkdiv_resetn = clkdiv_resetn_q;
  assign video_reset   = video_reset_q;
  assign clocks_ready  = clocks_ready_q;
  assign fault         = fault_q;
  assign retry_count   = rc_q;
  assign state_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_clock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_clock_sequencer
// Purpose  : Self-checking bench for hdmi_clock_sequencer. Expected state
//            transitions (state, cycle) are queued as stimulus is applied
//            and compared when the DUT changes state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_clock_sequencer;

  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_lock = 1'b0;
  logic          restart = 1'b0;
  logic          pll_reset;
  logic          clkdiv_resetn;
  logic          video_reset;
  logic          clocks_ready;
  logic          fault;
  logic [RW-1:0] retry_count;
  logic [2:0]    state_o;

  hdmi_clock_sequencer #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (20),
    .STABLE_CYCLES  (8),
    .DIV_SETTLE     (3),
    .MAX_RETRIES    (3),
    .SYNC_STAGES    (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_lock      (pll_lock),
    .restart       (restart),
    .pll_reset     (pll_reset),
    .clkdiv_resetn (clkdiv_resetn),
    .video_reset   (video_reset),
    .clocks_ready  (clocks_ready),
    .fault         (fault),
    .retry_count   (retry_count),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [2:0] st;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  logic [2:0] prev_state = 3'd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t cyc=%0d)", tag, act, exp, $time, cyc);
  endtask

  task automatic push(input logic [2:0] st, input int c);
    exp_t e;
    e.st  = st;
    e.cyc = c;
    sb_q.push_back(e);
  endtask

  // Returns just after the negedge at which cyc reaches t.
  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_state"},  state_o, 3'd0);
    check({pfx, "_pllrst"}, pll_reset, 1'b1);
    check({pfx, "_divrstn"}, clkdiv_resetn, 1'b0);
    check({pfx, "_vidrst"}, video_reset, 1'b1);
    check({pfx, "_ready"},  clocks_ready, 1'b0);
    check({pfx, "_fault"},  fault, 1'b0);
    check({pfx, "_retry"},  retry_count, 2'd0);
  endtask

  // Scoreboard consumer: every state change must match the next queued
  // expectation, and the outputs must match the state's decode.
  always @(negedge clk) begin
    exp_t e;
    if (state_o !== prev_state) begin
      if (sb_q.size() == 0) begin
        check("unexpected_state", state_o, prev_state);
      end else begin
        e = sb_q.pop_front();
        check("sb_state", state_o, e.st);
        check("sb_cycle", cyc, e.cyc);
      end
      check("dec_pllrst",  pll_reset,     (state_o == 3'd0) || (state_o == 3'd5));
      check("dec_divrstn", clkdiv_resetn, (state_o == 3'd3) || (state_o == 3'd4));
      check("dec_vidrst",  video_reset,   state_o != 3'd4);
      check("dec_ready",   clocks_ready,  state_o == 3'd4);
      check("dec_fault",   fault,         state_o == 3'd5);
      prev_state = state_o;
    end
  end

  initial begin
    int r, l, d, s, rr, f, g, h;

    // Reset values
    wait_until(3);
    check_reset_values("rst");

    // 1. Clean bring-up
    r = cyc;
    rst = 1'b0;
    push(3'd1, r + 4);               // pll_reset high exactly 4 cycles
    wait_until(r + 9);               // lock 5 cycles after pll_reset falls
    l = cyc;
    pll_lock = 1'b1;
    push(3'd2, l + 3);
    push(3'd3, l + 11);              // divider release 2+8 after lock sampled
    push(3'd4, l + 14);              // video release 3 later
    wait_until(l + 14);
    check("s1_ready", clocks_ready, 1'b1);
    check("s1_vidrst", video_reset, 1'b0);
    check("s1_retry", retry_count, 2'd0);
    check("s1_sb_empty", sb_q.size(), 0);

    // 4. Loss in RUN
    d = cyc;
    pll_lock = 1'b0;
    push(3'd0, d + 3);               // within SYNC_STAGES+1 cycles
    push(3'd1, d + 7);               // 4-cycle pll_reset pulse
    wait_until(d + 3);
    check("s4_ready", clocks_ready, 1'b0);
    check("s4_vidrst", video_reset, 1'b1);
    check("s4_retry", retry_count, 2'd1);

    // 2. Lock glitch during STABLE at stable count 5 (failure coincides
    //    with the terminal count and must win)
    wait_until(d + 8);
    pll_lock = 1'b1;
    s = d + 11;
    push(3'd2, s);
    wait_until(s + 5);
    pll_lock = 1'b0;
    push(3'd0, s + 8);
    wait_until(s + 8);
    pll_lock = 1'b1;
    check("s2_retry", retry_count, 2'd2);
    push(3'd1, s + 12);
    push(3'd2, s + 13);
    push(3'd3, s + 21);
    push(3'd4, s + 24);
    wait_until(s + 24);
    check("s2_ready", clocks_ready, 1'b1);
    check("s2_retry_kept", retry_count, 2'd2);

    // Restart clears retries, then 3. never lock
    rr = cyc;
    restart = 1'b1;
    pll_lock = 1'b0;
    push(3'd0, rr + 1);
    wait_until(rr + 1);
    restart = 1'b0;
    check("rs_retry", retry_count, 2'd0);
    push(3'd1, rr + 5);
    push(3'd0, rr + 25);
    push(3'd1, rr + 29);
    push(3'd0, rr + 49);
    push(3'd1, rr + 53);
    push(3'd5, rr + 73);
    wait_until(rr + 80);
    check("s3_fault", fault, 1'b1);
    check("s3_state", state_o, 3'd5);
    check("s3_retry", retry_count, 2'd3);
    check("s3_pllrst", pll_reset, 1'b1);
    check("s3_sb_empty", sb_q.size(), 0);

    // 5. Restart from FAULT
    f = cyc;
    restart = 1'b1;
    push(3'd0, f + 1);
    wait_until(f + 1);
    restart = 1'b0;
    check("s5_fault", fault, 1'b0);
    check("s5_retry", retry_count, 2'd0);
    check("s5_state", state_o, 3'd0);
    pll_lock = 1'b1;
    push(3'd1, f + 5);
    push(3'd2, f + 6);
    push(3'd3, f + 14);
    push(3'd4, f + 17);
    wait_until(f + 19);
    check("s5_ready", clocks_ready, 1'b1);

    // 6. Async reset mid-DIV_SETTLE
    g = cyc;
    restart = 1'b1;
    push(3'd0, g + 1);
    wait_until(g + 1);
    restart = 1'b0;
    push(3'd1, g + 5);
    push(3'd2, g + 6);
    push(3'd3, g + 14);
    wait_until(g + 15);
    check("s6_in_div", state_o, 3'd3);
    #2;
    rst = 1'b1;
    push(3'd0, g + 16);
    #1;
    check_reset_values("s6_async");
    wait_until(g + 17);
    h = cyc;
    rst = 1'b0;
    push(3'd1, h + 4);
    push(3'd2, h + 5);
    push(3'd3, h + 13);
    push(3'd4, h + 16);
    wait_until(h + 18);
    check("s6_ready", clocks_ready, 1'b1);
    check("final_sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
